// File: rtl/vp_cmd_sequencer.sv
// vp_cmd_sequencer
//   Command front end for the VectorProcessor (16 lanes x 32b, 512-word memory).
//   Commands are queued in a small FIFO and issued one per cycle onto the
//   processor's instruction / mem_addr / reg_select inputs, qualified by vp_en.
//   Load/store base addresses are bounds-checked before issue. Either a rejected
//   command or a processor-reported out-of-bound access parks the block in an
//   error state until err_clr.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready   command handshake; ready = FIFO not full
//   cmd_op/reg/addr   command: op (00 load, 01 store, 10 add, 11 mul), register, base address
//   vp_en             issue strobe; processor executes while high
//   vp_instruction    op presented to the processor
//   vp_mem_addr       address presented to the processor
//   vp_reg_select     register select presented to the processor
//   vp_out_of_bound   processor bound flag, meaningful while vp_en=1
//   err_clr           clears the error and resumes issue
//   err, err_addr     sticky error flag and address of the offending command
//   idle              FIFO empty, running, nothing being issued
//   issued_cnt        commands issued since reset (wraps)

module vp_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_WORDS  = 512,
  parameter int LANES      = 16,
  parameter int MUL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_reg,
  input  logic [8:0]  cmd_addr,
  output logic        vp_en,
  output logic [1:0]  vp_instruction,
  output logic [8:0]  vp_mem_addr,
  output logic [1:0]  vp_reg_select,
  input  logic        vp_out_of_bound,
  input  logic        err_clr,
  output logic        err,
  output logic [8:0]  err_addr,
  output logic        idle,
  output logic [15:0] issued_cnt
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  // Highest base address whose full LANES-word access still fits in memory.
  localparam logic [8:0] ADDR_LIMIT = 9'(MEM_WORDS - LANES);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_MUL   = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t state, state_d;

  // Command storage (data only, not reset)
  logic [1:0] fifo_op   [FIFO_DEPTH];
  logic [1:0] fifo_reg  [FIFO_DEPTH];
  logic [8:0] fifo_addr [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [HOLD_W-1:0] hold_cnt;
  logic              rej_pending;

  logic [1:0] head_op;
  logic [1:0] head_reg;
  logic [8:0] head_addr;
  logic       head_bad;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       issue;
  logic       reject;
  logic       oob_err;
  logic       clr;
  logic       hold_last;
  logic       vp_en_d;

  assign head_op    = fifo_op[rd_ptr];
  assign head_reg   = fifo_reg[rd_ptr];
  assign head_addr  = fifo_addr[rd_ptr];
  assign fifo_empty = (count == '0);
  assign cmd_ready  = (count != CNT_W'(FIFO_DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign head_bad   = ((head_op == OP_LOAD) || (head_op == OP_STORE)) &&
                      (head_addr > ADDR_LIMIT);
  assign idle       = fifo_empty && (state == ST_RUN) && !vp_en;

  // Final cycle of a multi-cycle multiply: the next command may issue now.
  assign hold_last  = (state == ST_HOLD) && (hold_cnt == '0);

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    issue   = 1'b0;
    reject  = 1'b0;
    oob_err = 1'b0;
    clr     = 1'b0;
    vp_en_d = 1'b0;
    case (state)
      ST_RUN, ST_HOLD: begin
        if (vp_en && vp_out_of_bound) begin
          // Processor fault outranks any pending issue.
          oob_err = 1'b1;
          state_d = ST_ERROR;
        end else if ((state == ST_RUN) || hold_last) begin
          if (fifo_empty) begin
            state_d = ST_RUN;
          end else if (head_bad) begin
            reject  = 1'b1;
            state_d = ST_ERROR;
          end else begin
            pop     = 1'b1;
            issue   = 1'b1;
            vp_en_d = 1'b1;
            state_d = ((head_op == OP_MUL) && (MUL_CYCLES > 1)) ? ST_HOLD : ST_RUN;
          end
        end else begin
          vp_en_d = 1'b1;
        end
      end
      ST_ERROR: begin
        if (err_clr) begin
          clr     = 1'b1;
          pop     = rej_pending;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_d;
    end
  end

  // FIFO control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]   <= cmd_op;
      fifo_reg[wr_ptr]  <= cmd_reg;
      fifo_addr[wr_ptr] <= cmd_addr;
    end
  end

  // Issue stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vp_en          <= 1'b0;
      vp_instruction <= '0;
      vp_mem_addr    <= '0;
      vp_reg_select  <= '0;
      issued_cnt     <= '0;
      hold_cnt       <= '0;
    end else begin
      vp_en <= vp_en_d;
      if (issue) begin
        vp_instruction <= head_op;
        vp_mem_addr    <= head_addr;
        vp_reg_select  <= head_reg;
        issued_cnt     <= issued_cnt + 16'd1;
      end
      if (issue && (head_op == OP_MUL)) begin
        hold_cnt <= HOLD_W'(MUL_CYCLES - 1);
      end else if ((state == ST_HOLD) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  // Error tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err         <= 1'b0;
      err_addr    <= '0;
      rej_pending <= 1'b0;
    end else begin
      if (oob_err) begin
        err         <= 1'b1;
        err_addr    <= vp_mem_addr;
        rej_pending <= 1'b0;
      end else if (reject) begin
        err         <= 1'b1;
        err_addr    <= head_addr;
        rej_pending <= 1'b1;
      end else if (clr) begin
        err         <= 1'b0;
        rej_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vp_cmd_sequencer.sv
module tb_vp_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_reg;
  logic [8:0]  cmd_addr;
  logic        vp_out_of_bound;
  logic        err_clr;

  logic        cmd_ready, vp_en, err, idle;
  logic [1:0]  vp_instruction, vp_reg_select;
  logic [8:0]  vp_mem_addr, err_addr;
  logic [15:0] issued_cnt;

  logic        m_cmd_ready, m_vp_en, m_err, m_idle;
  logic [1:0]  m_vp_instruction, m_vp_reg_select;
  logic [8:0]  m_vp_mem_addr, m_err_addr;
  logic [15:0] m_issued_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vp_cmd_sequencer #(.FIFO_DEPTH(4), .MEM_WORDS(512), .LANES(16), .MUL_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_addr(cmd_addr),
    .vp_en(vp_en), .vp_instruction(vp_instruction),
    .vp_mem_addr(vp_mem_addr), .vp_reg_select(vp_reg_select),
    .vp_out_of_bound(vp_out_of_bound), .err_clr(err_clr),
    .err(err), .err_addr(err_addr), .idle(idle), .issued_cnt(issued_cnt)
  );

  vp_cmd_sequencer #(.FIFO_DEPTH(4), .MEM_WORDS(512), .LANES(16), .MUL_CYCLES(3)) dut_m3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(m_cmd_ready),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_addr(cmd_addr),
    .vp_en(m_vp_en), .vp_instruction(m_vp_instruction),
    .vp_mem_addr(m_vp_mem_addr), .vp_reg_select(m_vp_reg_select),
    .vp_out_of_bound(vp_out_of_bound), .err_clr(err_clr),
    .err(m_err), .err_addr(m_err_addr), .idle(m_idle), .issued_cnt(m_issued_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [1:0] op, input logic [1:0] rg, input logic [8:0] addr);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_reg   = rg;
    cmd_addr  = addr;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_reg = '0; cmd_addr = '0;
    vp_out_of_bound = 1'b0; err_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_idle",   idle, 1);
    chk("rst_ready",  cmd_ready, 1);
    chk("rst_vp_en",  vp_en, 0);
    chk("rst_err",    err, 0);
    chk("rst_cnt",    issued_cnt, 0);
    chk("rst_instr",  vp_instruction, 0);

    // Back-to-back: load A1@0, load A2@16, add, mul
    set_cmd(2'b00, 2'd0, 9'd0);   tick();
    chk("b2b_pre_en", vp_en, 0);
    set_cmd(2'b00, 2'd1, 9'd16);  tick();
    chk("b2b1_en", vp_en, 1);
    chk("b2b1_op", vp_instruction, 0);
    chk("b2b1_addr", vp_mem_addr, 0);
    chk("b2b1_reg", vp_reg_select, 0);
    set_cmd(2'b10, 2'd2, 9'd0);   tick();
    chk("b2b2_en", vp_en, 1);
    chk("b2b2_op", vp_instruction, 0);
    chk("b2b2_addr", vp_mem_addr, 16);
    chk("b2b2_reg", vp_reg_select, 1);
    set_cmd(2'b11, 2'd3, 9'd0);   tick();
    chk("b2b3_en", vp_en, 1);
    chk("b2b3_op", vp_instruction, 2);
    cmd_valid = 1'b0;             tick();
    chk("b2b4_en", vp_en, 1);
    chk("b2b4_op", vp_instruction, 3);
    chk("b2b4_cnt", issued_cnt, 4);
    tick();
    chk("b2b_done_en", vp_en, 0);
    chk("b2b_done_idle", idle, 1);
    chk("b2b_hold_op", vp_instruction, 3);

    // Out-of-bound reported by processor during load @48
    set_cmd(2'b00, 2'd0, 9'd48);  tick();
    cmd_valid = 1'b0;             tick();
    chk("oob_issue_en", vp_en, 1);
    chk("oob_issue_addr", vp_mem_addr, 48);
    vp_out_of_bound = 1'b1;       tick();
    vp_out_of_bound = 1'b0;
    chk("oob_err", err, 1);
    chk("oob_err_addr", err_addr, 48);
    chk("oob_en_off", vp_en, 0);
    chk("oob_cnt", issued_cnt, 5);

    // Fill FIFO while in ERROR
    set_cmd(2'b01, 2'd0, 9'd496); tick();
    chk("fill1_ready", cmd_ready, 1);
    set_cmd(2'b01, 2'd1, 9'd497); tick();
    set_cmd(2'b10, 2'd1, 9'd7);   tick();
    chk("fill3_ready", cmd_ready, 1);
    set_cmd(2'b00, 2'd2, 9'd32);  tick();
    chk("full_ready", cmd_ready, 0);
    set_cmd(2'b11, 2'd3, 9'd1);   tick();
    chk("full_ready_hold", cmd_ready, 0);
    chk("err_no_issue", vp_en, 0);
    chk("err_sticky", err, 1);
    cmd_valid = 1'b0;

    // Clear processor-side error: nothing dropped
    err_clr = 1'b1;               tick();
    err_clr = 1'b0;
    chk("clr_err", err, 0);
    chk("clr_en", vp_en, 0);
    tick();
    chk("st496_en", vp_en, 1);
    chk("st496_op", vp_instruction, 1);
    chk("st496_addr", vp_mem_addr, 496);
    tick();
    chk("st497_err", err, 1);
    chk("st497_err_addr", err_addr, 497);
    chk("st497_en", vp_en, 0);
    chk("st497_cnt", issued_cnt, 6);

    // Clear reject: head dropped, add then load issue
    err_clr = 1'b1;               tick();
    err_clr = 1'b0;
    chk("rej_clr_err", err, 0);
    tick();
    chk("add_en", vp_en, 1);
    chk("add_op", vp_instruction, 2);
    chk("add_addr", vp_mem_addr, 7);
    tick();
    chk("ld32_op", vp_instruction, 0);
    chk("ld32_addr", vp_mem_addr, 32);
    chk("ld32_reg", vp_reg_select, 2);
    tick();
    chk("drain_en", vp_en, 0);
    chk("drain_idle", idle, 1);
    chk("drain_cnt", issued_cnt, 8);

    // err_clr outside ERROR is ignored
    err_clr = 1'b1;               tick();
    err_clr = 1'b0;
    chk("clr_ignored_idle", idle, 1);
    chk("clr_ignored_err", err, 0);

    // Load @500 rejected, then dropped; following add issues
    set_cmd(2'b00, 2'd0, 9'd500); tick();
    set_cmd(2'b10, 2'd3, 9'd5);   tick();
    cmd_valid = 1'b0;
    chk("ld500_err", err, 1);
    chk("ld500_err_addr", err_addr, 500);
    chk("ld500_en", vp_en, 0);
    tick();
    chk("ld500_still_err", err, 1);
    err_clr = 1'b1;               tick();
    err_clr = 1'b0;
    tick();
    chk("post500_en", vp_en, 1);
    chk("post500_op", vp_instruction, 2);
    chk("post500_reg", vp_reg_select, 3);
    chk("post500_addr", vp_mem_addr, 5);
    chk("post500_cnt", issued_cnt, 9);

    // MUL_CYCLES=3 instance: mul then add
    rst_n = 1'b0;                 tick();
    rst_n = 1'b1;                 tick();
    chk("m3_rst_idle", m_idle, 1);
    set_cmd(2'b11, 2'd1, 9'd0);   tick();
    set_cmd(2'b10, 2'd2, 9'd0);   tick();
    cmd_valid = 1'b0;
    chk("m3_c1_en", m_vp_en, 1);
    chk("m3_c1_op", m_vp_instruction, 3);
    tick();
    chk("m3_c2_en", m_vp_en, 1);
    chk("m3_c2_op", m_vp_instruction, 3);
    tick();
    chk("m3_c3_en", m_vp_en, 1);
    chk("m3_c3_op", m_vp_instruction, 3);
    tick();
    chk("m3_add_en", m_vp_en, 1);
    chk("m3_add_op", m_vp_instruction, 2);
    tick();
    chk("m3_done_en", m_vp_en, 0);
    chk("m3_cnt", m_issued_cnt, 2);

    // Reset in the middle of a multiply
    set_cmd(2'b11, 2'd1, 9'd9);   tick();
    cmd_valid = 1'b0;             tick();
    chk("m3_mid_en", m_vp_en, 1);
    rst_n = 1'b0;
    #1;
    chk("m3_rst_en", m_vp_en, 0);
    chk("m3_rst_op", m_vp_instruction, 0);
    chk("m3_rst_addr", m_vp_mem_addr, 0);
    chk("m3_rst_reg", m_vp_reg_select, 0);
    chk("m3_rst_cnt", m_issued_cnt, 0);
    chk("m3_rst_idle2", m_idle, 1);
    chk("m3_rst_ready", m_cmd_ready, 1);
    chk("m3_rst_err", m_err, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("m3_after_rst_en", m_vp_en, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
